// File: rtl/reg_bus_arb_pkg.sv
// ============================================================================
// Module : reg_bus_arb_pkg
// Brief  : Shared FSM state encoding and default widths for reg_bus_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package reg_bus_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/reg_bus_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker; first set request at or after ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_win_oh,
  output logic [IW-1:0]      o_win_idx,
  output logic               o_any
);

  logic w_found;
  int   w_j;

  always_comb begin
    w_found   = 1'b0;
    w_j       = 0;
    o_win_oh  = '0;
    o_win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      if (!w_found && i_req[w_j]) begin
        w_found       = 1'b1;
        o_win_oh[w_j] = 1'b1;
        o_win_idx     = IW'(w_j);
      end
    end
    o_any = |i_req;
  end

endmodule

`default_nettype wire

// File: rtl/reg_bus_arbiter.sv
// ============================================================================
// Module : reg_bus_arbiter
// Brief  : Round-robin arbiter funnelling N requesters onto one register bus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_bus_arbiter
  import reg_bus_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          en,
  output logic                          wr,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic [DATA_WIDTH-1:0]         wdata,
  input  logic [DATA_WIDTH-1:0]         rdata
);

  localparam int         c_IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0] c_LAT = 3'(RD_LATENCY);

  arb_state_e            r_state;
  logic [c_IW-1:0]       r_ptr;
  logic [NUM_REQ-1:0]    r_win_oh;
  logic [c_IW-1:0]       r_win_idx;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [2:0]            r_cnt;

  logic [NUM_REQ-1:0]    w_win_oh;
  logic [c_IW-1:0]       w_win_idx;
  logic                  w_any;
  logic                  w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (c_IW)
  ) u_rr_pick (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_win_oh  (w_win_oh),
    .o_win_idx (w_win_idx),
    .o_any     (w_any)
  );

  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_oh[i]) begin
        w_sel_wr    = req_wr[i];
        w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_win_oh  <= '0;
      r_win_idx <= '0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_win_oh  <= w_win_oh;
            r_win_idx <= w_win_idx;
            r_wr      <= w_sel_wr;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Clearing here makes write responses carry zero data.
          r_rdata <= '0;
          r_cnt   <= 3'd1;
          r_state <= r_wr ? ST_DONE : ST_WAIT_RD;
        end
        ST_WAIT_RD: begin
          if (r_cnt == c_LAT) begin
            r_rdata <= rdata;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        ST_DONE: begin
          r_ptr   <= (r_win_idx == c_IW'(NUM_REQ - 1)) ? '0 : r_win_idx + c_IW'(1);
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Grant is a Mealy pulse in IDLE; rstn gating keeps it low during reset.
  assign gnt       = (rstn && (r_state == ST_IDLE)) ? w_win_oh : '0;
  assign en        = (r_state == ST_ISSUE);
  assign wr        = en & r_wr;
  assign addr      = r_addr;
  assign wdata     = r_wdata;
  assign rsp_valid = (r_state == ST_DONE) ? r_win_oh : '0;
  assign rsp_rdata = (r_state == ST_DONE) ? r_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_reg_bus_arbiter.sv
// ============================================================================
// Module : tb_reg_bus_arbiter
// Brief  : Directed self-checking bench for reg_bus_arbiter with a toy target.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_bus_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  req_wr = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_rdata;
  logic        en;
  logic        wr;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];

  always #5 clk = ~clk;

  // Target with one cycle read latency.
  always @(posedge clk) begin
    if (en && wr) mem[addr] <= wdata;
    if (en && !wr) rdata <= mem[addr];
  end

  reg_bus_arbiter dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .en        (en),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic w, input logic [7:0] a, input logic [15:0] d);
    req_wr[i]              = w;
    req_addr[i*8 +: 8]     = a;
    req_wdata[i*16 +: 16]  = d;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      checks++;
      assert ($onehot0(gnt) && $onehot0(rsp_valid)) else begin
        errors++;
        $error("FAIL onehot: gnt %b rsp_valid %b expected onehot0", gnt, rsp_valid);
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_en", 64'(en), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_addr", 64'(addr), 64'h0);
    chk("rst_wdata", 64'(wdata), 64'h0);
    rstn = 1'b1;

    // Single write from requester 1
    @(negedge clk);
    set_lane(1, 1'b1, 8'h10, 16'hBEEF);
    req = 4'b0010;
    #1 chk("wr_gnt_T", 64'(gnt), 64'h2);
    @(posedge clk); #1 req = 4'b0000;
    @(negedge clk);
    chk("wr_en_T1", 64'(en), 64'h1);
    chk("wr_wr_T1", 64'(wr), 64'h1);
    chk("wr_addr_T1", 64'(addr), 64'h10);
    chk("wr_wdata_T1", 64'(wdata), 64'hBEEF);
    chk("wr_gnt_T1", 64'(gnt), 64'h0);
    @(negedge clk);
    chk("wr_rsp_T2", 64'(rsp_valid), 64'h2);
    chk("wr_rdata_T2", 64'(rsp_rdata), 64'h0);
    chk("wr_en_T2", 64'(en), 64'h0);
    chk("wr_addr_hold", 64'(addr), 64'h10);
    @(negedge clk);
    chk("wr_rsp_T3", 64'(rsp_valid), 64'h0);

    // Read back from requester 0
    @(negedge clk);
    set_lane(0, 1'b0, 8'h10, 16'h0000);
    req = 4'b0001;
    #1 chk("rd_gnt_T", 64'(gnt), 64'h1);
    @(posedge clk); #1 req = 4'b0000;
    @(negedge clk);
    chk("rd_en_T1", 64'(en), 64'h1);
    chk("rd_wr_T1", 64'(wr), 64'h0);
    chk("rd_addr_T1", 64'(addr), 64'h10);
    @(negedge clk);
    chk("rd_en_T2", 64'(en), 64'h0);
    chk("rd_rsp_T2", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    chk("rd_rsp_T3", 64'(rsp_valid), 64'h1);
    chk("rd_rdata_T3", 64'(rsp_rdata), 64'hBEEF);
    @(negedge clk);
    chk("rd_rsp_T4", 64'(rsp_valid), 64'h0);

    // All four requesting continuously from a fresh reset
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 8'(8'h30 + i), 16'(16'hA000 + i));
    req = 4'b1111;
    #1 chk("rr_gnt0", 64'(gnt), 64'h1);
    repeat (3) @(negedge clk);
    #1 chk("rr_gnt1", 64'(gnt), 64'h2);
    repeat (3) @(negedge clk);
    #1 chk("rr_gnt2", 64'(gnt), 64'h4);
    repeat (3) @(negedge clk);
    #1 chk("rr_gnt3", 64'(gnt), 64'h8);
    repeat (3) @(negedge clk);
    #1 chk("rr_gnt4", 64'(gnt), 64'h1);
    @(posedge clk); #1 req = 4'b0000;
    repeat (3) @(negedge clk);

    // Bring ptr to 3, then wrap with requesters 3 and 0
    req = 4'b0100;
    #1 chk("wrap_pre_gnt2", 64'(gnt), 64'h4);
    @(posedge clk); #1 req = 4'b1001;
    repeat (3) @(negedge clk);
    #1 chk("wrap_gnt3", 64'(gnt), 64'h8);
    repeat (3) @(negedge clk);
    #1 chk("wrap_gnt0", 64'(gnt), 64'h1);
    @(posedge clk); #1 req = 4'b0000;
    repeat (3) @(negedge clk);

    // Reset during WAIT_RD aborts the read
    set_lane(1, 1'b0, 8'h10, 16'h0000);
    req = 4'b0010;
    #1 chk("abort_gnt", 64'(gnt), 64'h2);
    @(posedge clk); #1 req = 4'b0000;
    @(negedge clk);
    chk("abort_en_issue", 64'(en), 64'h1);
    @(negedge clk);
    rstn = 1'b0;
    set_lane(2, 1'b1, 8'h20, 16'h1234);
    req = 4'b0100;
    #1;
    chk("abort_en", 64'(en), 64'h0);
    chk("abort_rsp", 64'(rsp_valid), 64'h0);
    chk("abort_gnt_in_rst", 64'(gnt), 64'h0);
    @(negedge clk);
    chk("abort_rsp_late", 64'(rsp_valid), 64'h0);
    rstn = 1'b1;
    #1 chk("post_rst_gnt2", 64'(gnt), 64'h4);
    @(posedge clk); #1 req = 4'b0000;
    @(negedge clk);
    chk("post_rst_en", 64'(en), 64'h1);
    chk("post_rst_addr", 64'(addr), 64'h20);
    @(negedge clk);
    chk("post_rst_rsp", 64'(rsp_valid), 64'h4);
    @(negedge clk);

    // Requester 3 drops req after grant; ptr wraps 3 -> 0 afterwards
    set_lane(3, 1'b0, 8'h33, 16'h0000);
    req = 4'b1000;
    #1 chk("drop_gnt", 64'(gnt), 64'h8);
    @(negedge clk);
    chk("drop_en", 64'(en), 64'h1);
    @(posedge clk); #1 req = 4'b0000;
    @(negedge clk);
    chk("drop_gnt_wait", 64'(gnt), 64'h0);
    @(negedge clk);
    chk("drop_rsp", 64'(rsp_valid), 64'h8);
    chk("drop_rdata", 64'(rsp_rdata), 64'hA003);
    @(negedge clk);
    chk("drop_no_regnt", 64'(gnt), 64'h0);
    chk("drop_rsp_clear", 64'(rsp_valid), 64'h0);
    req = 4'b1001;
    set_lane(0, 1'b1, 8'h40, 16'h5555);
    set_lane(3, 1'b1, 8'h41, 16'h6666);
    #1 chk("ptr_wrapped_gnt0", 64'(gnt), 64'h1);
    @(posedge clk); #1 req = 4'b0000;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
